// File: rtl/carp_mem_arbiter_if.sv
// carp_mem_arbiter_if: requester and memory-port signals of the CARP memory
// arbiter. The slave modport is the arbiter's view. The master modport is the
// view of the surrounding fetch, load/store and memory logic.
interface carp_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // load/store requester
  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_ack;

  // shared memory port
  logic                m_req;
  logic                m_we;
  logic [DATA_W/8-1:0] m_be;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_ack;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_rdata, d_ack,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/carp_mem_arbiter.sv
// carp_mem_arbiter: shares CARP's single memory port between instruction fetch
// and load/store. One transaction is outstanding at a time. Every output is
// registered. Data wins ties.
// Optional build macro CARP_ARB_FAIR_EN: a streak counter lets fetch win after
// MAX_STREAK back-to-back data grants made while fetch was waiting.
module carp_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input logic               CLK,
  input logic               RST,
  carp_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_t;

  state_t state;
  logic   owner_d;  // 1: current transaction belongs to load/store
  logic   grant_d;  // winner of the IDLE decision, 1 = data

  if (MAX_STREAK < 1) begin : g_bad_streak
    $error("carp_mem_arbiter: MAX_STREAK must be >= 1");
  end

`ifdef CARP_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(MAX_STREAK);

  logic [SW-1:0] streak;

  // Data wins unless fetch has waited through MAX_STREAK data grants in a row.
  always_comb begin
    grant_d = bus.d_req && !(bus.if_req && (streak == STREAK_LIM));
  end
`else
  // Strict data priority.
  always_comb begin
    grant_d = bus.d_req;
  end
`endif

  // Arbiter FSM. It registers the winner's command, captures read data and
  // pulses the owner's ack.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      bus.m_req    <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.m_be     <= '0;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
      bus.if_ack   <= 1'b0;
      bus.d_ack    <= 1'b0;
`ifdef CARP_ARB_FAIR_EN
      streak       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            bus.m_req <= 1'b1;
            owner_d   <= grant_d;
            state     <= MEM;
            if (grant_d) begin
              bus.m_we    <= bus.d_we;
              bus.m_be    <= bus.d_be;
              bus.m_addr  <= bus.d_addr;
              bus.m_wdata <= bus.d_wdata;
            end else begin
              bus.m_we    <= 1'b0;
              bus.m_be    <= '1;
              bus.m_addr  <= bus.if_addr;
              bus.m_wdata <= '0;
            end
`ifdef CARP_ARB_FAIR_EN
            // Count only data grants that made fetch wait.
            if (grant_d && bus.if_req) begin
              streak <= streak + 1'b1;
            end else begin
              streak <= '0;
            end
`endif
          end
        end
        MEM: begin
          if (bus.m_ack) begin
            bus.m_req <= 1'b0;
            state     <= RESP;
            if (owner_d) begin
              bus.d_rdata <= bus.m_rdata;
              bus.d_ack   <= 1'b1;
            end else begin
              bus.if_rdata <= bus.m_rdata;
              bus.if_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          // The owner still holds its request here, so it cannot be re-granted.
          bus.if_ack <= 1'b0;
          bus.d_ack  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carp_mem_arbiter.sv
// tb_carp_mem_arbiter: directed and randomized checks of carp_mem_arbiter.
// The reference is transaction-level. The arbiter is free again two edges
// after an ack. A grant goes to data unless the fairness rule says otherwise.
// Each transaction then runs for k+1 memory cycles and ends in a one-cycle ack.
module tb_carp_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MS = 4;
`ifdef CARP_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic CLK;
  logic RST;

  carp_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  carp_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state
  bit          busy, ack_due, own_d, chk_wd;
  int          wcnt, kcur, free_edge, streak;
  logic [DW-1:0] pend_rdata, exp_if_rdata, exp_d_rdata, exp_wdata;
  logic [AW-1:0] exp_addr;
  logic          exp_we;
  logic [BW-1:0] exp_be;
  int            grant_cyc, ack_cyc, n_if_ack, n_d_ack;

  // stimulus controls
  int          k_fixed;
  bit          data_fixed_en, spur_en, rnd_en, if_auto, d_auto, if_rel, d_rel;
  logic [DW-1:0] data_fixed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic issue_if(input logic [AW-1:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic issue_d(input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_be    = be;
    bus.d_addr  = a;
    bus.d_wdata = wd;
  endtask

  task automatic check_rdata();
    chk("if_rdata", bus.if_rdata, exp_if_rdata);
    chk("d_rdata", bus.d_rdata, exp_d_rdata);
  endtask

  // One clock: check the DUT against the model, then drive memory and requesters.
  task automatic tick();
    logic rst_s, ifr, dr;
    bit   win_d, new_if_rel, new_d_rel;
    rst_s = RST;
    ifr   = bus.if_req;
    dr    = bus.d_req;
    new_if_rel = 1'b0;
    new_d_rel  = 1'b0;
    @(posedge CLK);
    #1;
    cyc++;
    if (rst_s) begin
      chk("rst_m_req", bus.m_req, 0);
      chk("rst_m_we", bus.m_we, 0);
      chk("rst_m_be", bus.m_be, 0);
      chk("rst_m_addr", bus.m_addr, 0);
      chk("rst_m_wdata", bus.m_wdata, 0);
      chk("rst_if_ack", bus.if_ack, 0);
      chk("rst_d_ack", bus.d_ack, 0);
      busy = 0; ack_due = 0; streak = 0; free_edge = cyc + 1;
      exp_if_rdata = '0; exp_d_rdata = '0;
      check_rdata();
    end else if (ack_due) begin
      chk("if_ack", bus.if_ack, !own_d);
      chk("d_ack", bus.d_ack, own_d);
      chk("m_req_drop", bus.m_req, 0);
      if (own_d) begin
        exp_d_rdata = pend_rdata; n_d_ack++; new_d_rel = 1'b1;
      end else begin
        exp_if_rdata = pend_rdata; n_if_ack++; new_if_rel = 1'b1;
      end
      check_rdata();
      ack_cyc = cyc; busy = 0; ack_due = 0; free_edge = cyc + 2;
    end else begin
      if (!busy && cyc >= free_edge && (ifr || dr)) begin
        win_d = dr && !(FAIR && ifr && streak == MS);
        if (win_d && ifr) streak = streak + 1;
        else streak = 0;
        own_d = win_d;
        if (win_d) begin
          exp_we = bus.d_we; exp_be = bus.d_be; exp_addr = bus.d_addr;
          exp_wdata = bus.d_wdata; chk_wd = 1'b1;
        end else begin
          exp_we = 1'b0; exp_be = '1; exp_addr = bus.if_addr; chk_wd = 1'b0;
        end
        busy = 1; wcnt = 0; grant_cyc = cyc;
        kcur = (k_fixed >= 0) ? k_fixed : int'($urandom_range(0, 3));
      end
      chk("m_req", bus.m_req, busy);
      if (busy) begin
        chk("m_we", bus.m_we, exp_we);
        chk("m_be", bus.m_be, exp_be);
        chk("m_addr", bus.m_addr, exp_addr);
        if (chk_wd) chk("m_wdata", bus.m_wdata, exp_wdata);
      end
      chk("if_ack_idle", bus.if_ack, 0);
      chk("d_ack_idle", bus.d_ack, 0);
      check_rdata();
    end

    // memory model: ack after kcur wait cycles, random data otherwise
    if (busy) begin
      if (wcnt == kcur) begin
        pend_rdata  = data_fixed_en ? data_fixed : $urandom;
        bus.m_rdata = pend_rdata;
        bus.m_ack   = 1'b1;
        ack_due     = 1;
      end else begin
        bus.m_rdata = $urandom;
        bus.m_ack   = 1'b0;
      end
      wcnt++;
    end else begin
      bus.m_rdata = $urandom;
      bus.m_ack   = spur_en && ($urandom_range(0, 3) == 0);
    end

    // requesters drop the cycle after their ack
    if (if_rel) begin
      bus.if_req = 1'b0; if_rel = 0;
      if (if_auto) issue_if($urandom & 32'hFFFF_FFFC);
    end
    if (d_rel) begin
      bus.d_req = 1'b0; d_rel = 0;
      if (d_auto) issue_d($urandom_range(0, 1), $urandom, $urandom, $urandom);
    end
    if (new_if_rel) if_rel = 1;
    if (new_d_rel) d_rel = 1;
    if (rnd_en) begin
      if (!bus.if_req && $urandom_range(0, 2) == 0) issue_if($urandom & 32'hFFFF_FFFC);
      if (!bus.d_req && $urandom_range(0, 2) == 0)
        issue_d($urandom_range(0, 1), $urandom, $urandom, $urandom);
    end
  endtask

  task automatic run_until_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !bus.if_req && !bus.d_req && !if_rel && !d_rel) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("idle_reached", ok, 1);
  endtask

  initial begin
    int  d_before;
    bit  hit;
    RST = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0; bus.m_ack = 0;
    busy = 0; ack_due = 0; own_d = 0; chk_wd = 0; wcnt = 0; kcur = 0;
    free_edge = 0; streak = 0; n_if_ack = 0; n_d_ack = 0; grant_cyc = 0; ack_cyc = 0;
    exp_if_rdata = '0; exp_d_rdata = '0; pend_rdata = '0;
    k_fixed = 0; data_fixed_en = 1; data_fixed = 32'hDEADBEEF;
    spur_en = 0; rnd_en = 0; if_auto = 0; d_auto = 0; if_rel = 0; d_rel = 0;

    // reset held two cycles with both requests high, then data wins first
    issue_if(32'h100);
    issue_d(1'b0, 4'hF, 32'h300, 32'h0);
    tick();
    tick();
    RST = 1'b0;
    run_until_idle(50);
    chk("sim_order", n_d_ack + n_if_ack, 2);

    // single fetch, k=0
    d_before = n_d_ack;
    issue_if(32'h100);
    run_until_idle(20);
    chk("fetch_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk("fetch_latency", ack_cyc - grant_cyc, 1);
    chk("fetch_no_dack", n_d_ack - d_before, 0);

    // data write with three wait states
    k_fixed = 3;
    data_fixed = 32'h0BAD_F00D;
    issue_d(1'b1, 4'h3, 32'h200, 32'h1234);
    run_until_idle(20);
    chk("wr_latency", ack_cyc - grant_cyc, 4);

    // reset during a k=5 memory wait abandons the transaction
    k_fixed = 5;
    data_fixed = 32'hCAFE_0042;
    issue_d(1'b0, 4'hF, 32'h400, 32'h0);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy && wcnt == 3) begin
        hit = 1;
        break;
      end
    end
    chk("mem_wait_reached", hit, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_m_req", bus.m_req, 0);
    run_until_idle(30);
    chk("post_rst_rdata", bus.d_rdata, 32'hCAFE_0042);

    // fetch held while data keeps re-requesting
    RST = 1'b1;
    tick();
    RST = 1'b0;
    k_fixed = -1;
    data_fixed_en = 0;
    n_d_ack = 0;
    n_if_ack = 0;
    if_auto = 1;
    d_auto = 1;
    issue_if(32'h500);
    issue_d(1'b0, 4'hF, 32'h600, 32'h0);
    for (int i = 0; i < 600; i++) begin
      if (n_d_ack >= 20) break;
      tick();
    end
    chk("fair_d_count", n_d_ack, 20);
    chk("fair_if_count", n_if_ack, FAIR ? 4 : 0);
    if_auto = 0;
    d_auto = 0;
    run_until_idle(100);

    // randomized traffic with spurious memory acks outside MEM
    rnd_en = 1;
    spur_en = 1;
    repeat (400) tick();
    rnd_en = 0;
    run_until_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
